led_fade_driver: RTL and testbench
==================================

LED_FADE_DRIVER -- requirements
Module: led_fade_driver

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; ports are named clk and reset_n.
REQ-002 Parameter NUM_LEDS, 10, number of LED channels.
REQ-003 Parameter DEFAULT_DECAY, 16'd49999, reset value of the DECAY register in clk cycles minus one.
REQ-004 Ports, one per line:
- clk  in  1  system clock
- reset_n  in  1  async active-low reset
- address  in  2  Avalon-MM slave word address
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe
- writedata  in  32  write data
- readdata  out  32  read data, zero read latency
- led_in  in  NUM_LEDS  LED request pattern from the LED PIO out_port, same clock domain
- led_out  out  NUM_LEDS  PWM-dimmed drive to the board LEDs

Function
REQ-005 Register map SHALL be:
- addr 0 CTRL RW: bit0 enable, bit1 fade_en
- addr 1 DECAY RW: bits[15:0]
- addr 2 STATUS RO: bits[NUM_LEDS-1:0] = led_out
- addr 3 reads 0
- unused readdata bits read 0
REQ-006 A write SHALL occur when chipselect=1 and write_n=0; writes to addr 2 and addr 3 SHALL be ignored.
REQ-007 readdata SHALL be a combinational function of address and the current register values.
REQ-008 Each channel SHALL hold a 4-bit level in the range 0..15.
REQ-009 A 4-bit pwm_cnt SHALL count 0..14 and wrap to 0, giving a 15-cycle period.
REQ-010 A 16-bit prescaler SHALL count 0..DECAY; tick SHALL be 1 for the single cycle in which prescaler==DECAY, and the prescaler SHALL return to 0 on that cycle.
REQ-011 DECAY=0 SHALL make tick=1 every cycle.
REQ-012 Any write to DECAY SHALL clear the prescaler to 0 on the same edge, with no tick on that edge.
REQ-013 Level update per channel, per cycle, in priority order:
- enable=0: level<=0
- led_in[i]=1: level<=15
- fade_en=0: level<=0
- tick=1 and level>0: level<=level-1
- otherwise: hold
REQ-014 Level SHALL saturate at 0 and SHALL never wrap.
REQ-015 led_out[i] SHALL be a register loaded with (enable && level[i] > pwm_cnt). Level 15 is therefore always on and level 0 always off.
REQ-016 Latency SHALL be 2 cycles: led_in rising at edge N gives level=15 at N+1 and led_out=1 at N+2.
REQ-017 A write to CTRL changing enable or fade_en SHALL take effect on level from the next edge.
REQ-018 When led_in reasserts mid-fade, the channel SHALL reload to 15 immediately; this overrides a coincident tick.

Reset
REQ-019 While reset_n=0, all of the following SHALL be cleared:
- CTRL=2'b11
- DECAY=DEFAULT_DECAY
- prescaler=0, pwm_cnt=0
- all levels=0
- led_out=0
REQ-020 Reset assertion mid-fade SHALL clear state asynchronously; the first post-reset edge SHALL behave as from power-up.

Structure
REQ-021 Package led_fade_pkg SHALL hold the following; nothing else is shared:
- LEVEL_MAX=15
- PWM_PERIOD=15
- register address constants CTRL/DECAY/STATUS
- CTRL bit indices
REQ-022 Sub-module led_fade_channel SHALL implement one channel's level register and output compare, and SHALL be instantiated NUM_LEDS times.
REQ-023 The prescaler, pwm_cnt and register file SHALL reside in led_fade_driver.

Verification
REQ-024 Reset, then read addr0/1/2/3 -> 0x3, 0xC34F, 0x0, 0x0.
REQ-025 Write DECAY=3, pulse led_in[0] for 1 cycle -> level 15 for 2 ticks' worth, then decrements 15->0 once every 4 cycles; led_out[0] duty over each 15-cycle window matches level/15; stays 0 once level=0.
REQ-026 Write DECAY=0, CTRL=0x1 (fade off), toggle led_in=0x2AA -> led_out follows exactly 2 cycles later with no fade.
REQ-027 Hold led_in[9]=1 while a tick coincides -> level stays 15 and led_out[9] is continuously 1.
REQ-028 Mid-fade, write CTRL=0 -> all led_out=0 within 2 cycles and STATUS reads 0; re-enable -> LEDs stay dark until led_in reasserts.
REQ-029 Assert reset_n=0 mid-fade with DECAY=7 -> led_out=0 immediately and DECAY reads 0xC34F after release.

Source files
------------

// File: rtl/led_fade_pkg.sv
// Shared constants for the LED fade driver: level range, PWM period,
// register word addresses and CTRL bit positions.
package led_fade_pkg;

  localparam int unsigned LEVEL_MAX  = 15;
  localparam int unsigned PWM_PERIOD = 15;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_DECAY  = 2'd1;
  localparam logic [1:0] ADDR_STATUS = 2'd2;

  localparam int unsigned CTRL_ENABLE  = 0;
  localparam int unsigned CTRL_FADE_EN = 1;

endpackage

// File: rtl/led_fade_channel.sv
// One LED channel: a 4-bit brightness level that reloads on request and
// decays on prescaler ticks, compared against the shared PWM counter.
module led_fade_channel
  import led_fade_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       enable,
  input  logic       fade_en,
  input  logic       tick,
  input  logic       led_req,
  input  logic [3:0] pwm_cnt,
  output logic       led
);

  logic [3:0] level_p1;
  logic       led_p2;

  // Stage 1: level update; a request overrides a coincident decay tick.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      level_p1 <= '0;
    end else if (!enable) begin
      level_p1 <= '0;
    end else if (led_req) begin
      level_p1 <= 4'(LEVEL_MAX);
    end else if (!fade_en) begin
      level_p1 <= '0;
    end else if (tick && (level_p1 != 4'd0)) begin
      level_p1 <= level_p1 - 4'd1;
    end
  end

  // Stage 2: registered PWM compare.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      led_p2 <= 1'b0;
    end else begin
      led_p2 <= enable && (level_p1 > pwm_cnt);
    end
  end

  assign led = led_p2;

endmodule

// File: rtl/led_fade_driver.sv
// Avalon-MM controlled LED fader: register file, decay prescaler and shared
// PWM counter feeding NUM_LEDS independent fade channels.
module led_fade_driver
  import led_fade_pkg::*;
#(
  parameter int          NUM_LEDS      = 10,
  parameter logic [15:0] DEFAULT_DECAY = 16'd49999
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [1:0]          address,
  input  logic                chipselect,
  input  logic                write_n,
  input  logic [31:0]         writedata,
  output logic [31:0]         readdata,
  input  logic [NUM_LEDS-1:0] led_in,
  output logic [NUM_LEDS-1:0] led_out
);

  logic [1:0]  ctrl;
  logic [15:0] decay;
  logic [15:0] prescaler;
  logic [3:0]  pwm_cnt;
  logic        wr_en;
  logic        decay_wr;
  logic        tick;
  logic        unused_wdata;

  assign wr_en        = chipselect && !write_n;
  assign decay_wr     = wr_en && (address == ADDR_DECAY);
  assign unused_wdata = ^writedata[31:16];

  // A DECAY write restarts the prescaler and suppresses the tick on that edge.
  assign tick = !decay_wr && (prescaler == decay);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl  <= 2'b11;
      decay <= DEFAULT_DECAY;
    end else if (wr_en) begin
      if (address == ADDR_CTRL) begin
        ctrl <= writedata[1:0];
      end
      if (address == ADDR_DECAY) begin
        decay <= writedata[15:0];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prescaler <= '0;
      pwm_cnt   <= '0;
    end else begin
      if (decay_wr || tick) begin
        prescaler <= '0;
      end else begin
        prescaler <= prescaler + 16'd1;
      end
      if (pwm_cnt == 4'(PWM_PERIOD - 1)) begin
        pwm_cnt <= '0;
      end else begin
        pwm_cnt <= pwm_cnt + 4'd1;
      end
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_CTRL:   readdata[1:0]          = ctrl;
      ADDR_DECAY:  readdata[15:0]         = decay;
      ADDR_STATUS: readdata[NUM_LEDS-1:0] = led_out;
      default:     readdata               = '0;
    endcase
  end

  for (genvar i = 0; i < NUM_LEDS; i++) begin : g_chan
    led_fade_channel u_chan (
      .clk     (clk),
      .reset_n (reset_n),
      .enable  (ctrl[CTRL_ENABLE]),
      .fade_en (ctrl[CTRL_FADE_EN]),
      .tick    (tick),
      .led_req (led_in[i]),
      .pwm_cnt (pwm_cnt),
      .led     (led_out[i])
    );
  end

endmodule

// File: tb/tb_led_fade_driver.sv
// Scoreboard bench for led_fade_driver: an integer reference model predicts
// led_out every cycle and readdata for every read; monitors pop and compare.
module tb_led_fade_driver;

  localparam int N = 10;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [1:0]    address;
  logic          chipselect;
  logic          write_n;
  logic [31:0]   writedata;
  logic [31:0]   readdata;
  logic [N-1:0]  led_in;
  logic [N-1:0]  led_out;

  led_fade_driver #(.NUM_LEDS(N), .DEFAULT_DECAY(16'd49999)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .led_in     (led_in),
    .led_out    (led_out)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state, plain integers.
  int           m_en, m_fe, m_decay, m_presc, m_pwm;
  int           m_level [N];
  logic [N-1:0] m_led;

  logic [N-1:0] led_q [$];
  logic [31:0]  rd_exp_q [$];
  logic [1:0]   rd_addr_q [$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", nm, $time, act, exp);
    end
  endtask

  function automatic void model_reset();
    m_en    = 1;
    m_fe    = 1;
    m_decay = 49999;
    m_presc = 0;
    m_pwm   = 0;
    foreach (m_level[i]) m_level[i] = 0;
    m_led   = '0;
  endfunction

  function automatic logic [31:0] model_read(input logic [1:0] a);
    case (a)
      2'd0:    return 32'(m_en + 2 * m_fe);
      2'd1:    return 32'(m_decay);
      2'd2:    return 32'(m_led);
      default: return 32'd0;
    endcase
  endfunction

  always @(negedge reset_n) model_reset();

  always @(posedge clk) begin
    if (!reset_n) begin
      model_reset();
    end else begin
      bit           wr, dwr, tick;
      logic [N-1:0] nxt;
      wr   = chipselect && !write_n;
      dwr  = wr && (address == 2'd1);
      tick = !dwr && (m_presc == m_decay);
      for (int i = 0; i < N; i++) begin
        nxt[i] = (m_en != 0) && (m_level[i] > m_pwm);
        if (m_en == 0)                      m_level[i] = 0;
        else if (led_in[i])                 m_level[i] = 15;
        else if (m_fe == 0)                 m_level[i] = 0;
        else if (tick && m_level[i] > 0)    m_level[i] = m_level[i] - 1;
      end
      m_led   = nxt;
      m_presc = (dwr || tick) ? 0 : m_presc + 1;
      m_pwm   = (m_pwm + 1) % 15;
      if (wr && address == 2'd0) begin
        m_en = int'(writedata[0]);
        m_fe = int'(writedata[1]);
      end
      if (dwr) m_decay = int'(writedata[15:0]);
    end
    led_q.push_back(m_led);
  end

  always @(posedge clk) begin
    #1;
    if (led_q.size() > 0) begin
      logic [N-1:0] e;
      e = led_q.pop_front();
      check("led_out", 32'(led_out), 32'(e));
    end
  end

  always @(negedge clk) begin
    #2;
    while (rd_exp_q.size() > 0) begin
      logic [31:0] e;
      logic [1:0]  a;
      e = rd_exp_q.pop_front();
      a = rd_addr_q.pop_front();
      check($sformatf("readdata[addr%0d]", a), readdata, e);
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic reg_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = a;
    writedata  = d;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic reg_read(input logic [1:0] a);
    @(negedge clk);
    address = a;
    rd_addr_q.push_back(a);
    rd_exp_q.push_back(model_read(a));
  endtask

  task automatic pulse_leds(input logic [N-1:0] p);
    @(negedge clk);
    led_in = p;
    @(negedge clk);
    led_in = '0;
  endtask

  task automatic async_reset();
    @(negedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    check("led_out_async_reset", 32'(led_out), 32'd0);
    cycles(2);
    reset_n = 1'b1;
  endtask

  initial begin
    model_reset();
    reset_n    = 1'b0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    address    = 2'd0;
    writedata  = '0;
    led_in     = '0;
    cycles(3);
    reset_n = 1'b1;

    // Register reset values.
    for (int a = 0; a < 4; a++) reg_read(2'(a));

    // Slow fade of channel 0 with DECAY=3.
    reg_write(2'd1, 32'd3);
    pulse_leds(10'h001);
    for (int k = 0; k < 90; k++) begin
      if (k % 7 == 0) reg_read(2'd2);
      else cycles(1);
    end

    // Fade disabled, fast toggling follows led_in directly.
    reg_write(2'd1, 32'd0);
    reg_write(2'd0, 32'h1);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      led_in = (k % 2 == 0) ? 10'h2AA : 10'h000;
    end
    led_in = '0;
    cycles(4);

    // led_in[9] held through ticks.
    reg_write(2'd0, 32'h3);
    reg_write(2'd1, 32'd2);
    @(negedge clk);
    led_in = 10'h200;
    cycles(30);
    led_in = '0;

    // Disable mid-fade, then re-enable.
    reg_write(2'd1, 32'd3);
    pulse_leds('1);
    cycles(10);
    reg_write(2'd0, 32'h0);
    cycles(2);
    reg_read(2'd2);
    reg_write(2'd0, 32'h3);
    cycles(20);
    reg_read(2'd2);
    pulse_leds(10'h155);
    cycles(10);

    // Asynchronous reset mid-fade.
    reg_write(2'd1, 32'd7);
    pulse_leds('1);
    cycles(20);
    async_reset();
    reg_read(2'd1);
    reg_read(2'd0);

    // Randomized traffic.
    for (int k = 0; k < 400; k++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 8) begin
        reg_write(2'd0, 32'($urandom_range(0, 3)));
      end else if (r < 14) begin
        reg_write(2'($urandom_range(1, 3)), 32'($urandom_range(0, 5)));
      end else if (r < 24) begin
        reg_read(2'($urandom_range(0, 3)));
      end else if (r < 25) begin
        async_reset();
      end else begin
        @(negedge clk);
        led_in = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
      end
    end
    led_in = '0;
    cycles(5);

    check("led_queue_drained", 32'(led_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
